// File: rtl/game_pad_mmio.sv
// game_pad_mmio: memory-mapped controller for an NES-style 8-button serial pad.
// Scans the pad periodically over latch/clock/data and publishes a read-only
// button-state register and a write-1-to-clear sticky press-edge register.
// Optional feature macro: GAME_PAD_DEBOUNCE_EN (status bit changes only when
// two consecutive scans agree on it).
module game_pad_mmio #(
  parameter logic [15:0] POLL_DIV    = 16'd50000,
  parameter logic [15:0] HALF_PERIOD = 16'd300,
  parameter logic [15:0] STATE_ADDR  = 16'h03FF,
  parameter logic [15:0] EDGE_ADDR   = 16'h03FE
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad_data,
  input  logic [15:0] addr,
  input  logic        write_en,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        sel,
  output logic        sample_valid
);

  // Terminal counts for each timed phase; 17 bits so 2*HALF_PERIOD cannot overflow
  localparam logic [16:0] POLL_LAST  = 17'(POLL_DIV) - 17'd1;
  localparam logic [16:0] HALF_LAST  = 17'(HALF_PERIOD) - 17'd1;
  localparam logic [16:0] LATCH_LAST = {HALF_PERIOD, 1'b0} - 17'd1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    COMMIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [16:0] cnt;
  logic [16:0] cnt_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_next;
  logic        sample_now;
  logic        commit;

  logic        sync_ff1;
  logic        sync_ff2;
  logic        pad_bit;
  logic [7:0]  scan_byte;
  logic [7:0]  status;
  logic [7:0]  edges;
  logic [7:0]  new_status;
  logic [7:0]  clear_mask;
  logic [7:0]  edges_next;
  logic        state_hit;
  logic        edge_hit;
  logic        unused_wr_hi;

  assign pad_bit      = ~sync_ff2;
  assign state_hit    = (addr == STATE_ADDR);
  assign edge_hit     = (addr == EDGE_ADDR);
  assign unused_wr_hi = ^wr_data[15:8];

  // FSM state, phase counter and bit index registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 17'd0;
      bit_idx <= 3'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
    end
  end

  // Next-state logic: each phase counts to its terminal value, then reloads
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 17'd1;
    bit_next   = bit_idx;
    sample_now = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (cnt == POLL_LAST) begin
          state_next = LATCH;
          cnt_next   = 17'd0;
          bit_next   = 3'd0;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          sample_now = 1'b1;
          state_next = SHIFT_LO;
          cnt_next   = 17'd0;
          bit_next   = 3'd1;
        end
      end
      SHIFT_LO: begin
        if (cnt == HALF_LAST) begin
          state_next = SHIFT_HI;
          cnt_next   = 17'd0;
        end
      end
      SHIFT_HI: begin
        if (cnt == HALF_LAST) begin
          sample_now = 1'b1;
          cnt_next   = 17'd0;
          if (bit_idx == 3'd7) begin
            state_next = COMMIT;
          end else begin
            state_next = SHIFT_LO;
            bit_next   = bit_idx + 3'd1;
          end
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
        cnt_next   = 17'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 17'd0;
      end
    endcase
  end

  // Two-flop synchronizer for the asynchronous pad data line (idles high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff1 <= 1'b1;
      sync_ff2 <= 1'b1;
    end else begin
      sync_ff1 <= pad_data;
      sync_ff2 <= sync_ff1;
    end
  end

  // Registered pad strobes decoded from the upcoming state so they are glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
    end else begin
      pad_latch <= (state_next == LATCH);
      pad_clk   <= (state_next != SHIFT_LO);
    end
  end

  // Capture each button bit at the end of its latch/high phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_byte <= 8'h00;
    end else if (sample_now) begin
      scan_byte[bit_idx] <= pad_bit;
    end
  end

`ifdef GAME_PAD_DEBOUNCE_EN
  logic [7:0] prev_scan;
  logic [7:0] stable;

  assign stable = ~(scan_byte ^ prev_scan);

  // Remember the previous scan so a bit must repeat before it reaches status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_scan <= 8'h00;
    end else if (commit) begin
      prev_scan <= scan_byte;
    end
  end

  // Stable bits take the new scan, unstable bits hold their current status
  always_comb begin
    new_status = (scan_byte & stable) | (status & ~stable);
  end
`else
  // Status follows every scan directly
  always_comb begin
    new_status = scan_byte;
  end
`endif

  // Clear first, then OR in new presses so a same-cycle set wins
  always_comb begin
    clear_mask = (write_en && edge_hit) ? wr_data[7:0] : 8'h00;
    edges_next = edges & ~clear_mask;
    if (commit) begin
      edges_next = edges_next | (new_status & ~status);
    end
  end

  // Button status, sticky edges and the commit pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status       <= 8'h00;
      edges        <= 8'h00;
      sample_valid <= 1'b0;
    end else begin
      edges        <= edges_next;
      sample_valid <= commit;
      if (commit) begin
        status <= new_status;
      end
    end
  end

  // One-cycle registered read port, matching synchronous RAM latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel     <= 1'b0;
      rd_data <= 16'h0000;
    end else begin
      sel <= state_hit || edge_hit;
      if (state_hit) begin
        rd_data <= {8'h00, status};
      end else if (edge_hit) begin
        rd_data <= {8'h00, edges};
      end else begin
        rd_data <= 16'h0000;
      end
    end
  end

endmodule
